// File: rtl/cart_pkg.sv
// Shared constants and types for the ASCII-family banked cartridge mapper.
package cart_pkg;

    localparam logic [15:0] WIN_LO   = 16'h4000;
    localparam logic [15:0] WIN_HI   = 16'hBFFF;
    localparam logic [2:0]  REG_BASE = 3'b011;

    localparam int BANK_BITS_ASCII8  = 13;
    localparam int BANK_BITS_ASCII16 = 14;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        REQ
    } save_state_t;

endpackage

// File: rtl/cart_sram_saver.sv
// Battery-SRAM save handshake: tracks writes and asks the host to save after a quiet period.
//
//   state | meaning
//   IDLE  | SRAM clean, nothing pending
//   QUIET | SRAM dirty, counting down quiet cycles since the last write
//   REQ   | save_req asserted, waiting for save_ack
module cart_sram_saver
    import cart_pkg::*;
#(
    parameter logic [23:0] SAVE_DELAY = 24'd3_579_545
) (
    input  logic clk,
    input  logic reset,
    input  logic sram_we,
    input  logic save_ack,
    output logic sram_dirty,
    output logic save_req
);

    save_state_t state, state_n;
    logic [23:0] quiet_cnt, quiet_cnt_n;
    logic        dirty, dirty_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            quiet_cnt <= '0;
            dirty     <= 1'b0;
        end else begin
            state     <= state_n;
            quiet_cnt <= quiet_cnt_n;
            dirty     <= dirty_n;
        end
    end

    // A write always wins, including over a concurrent save_ack in REQ.
    always_comb begin
        state_n     = state;
        quiet_cnt_n = quiet_cnt;
        dirty_n     = dirty;
        if (sram_we) begin
            dirty_n     = 1'b1;
            quiet_cnt_n = SAVE_DELAY;
            state_n     = QUIET;
        end else begin
            case (state)
                IDLE: ;
                QUIET: begin
                    if (quiet_cnt == '0) state_n = REQ;
                    else                 quiet_cnt_n = quiet_cnt - 24'd1;
                end
                REQ: begin
                    if (save_ack) begin
                        dirty_n = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sram_dirty = dirty;
    assign save_req   = (state == REQ);

endmodule

// File: rtl/cart_ascii_banked.sv
// ASCII8/ASCII16-style MSX mapper: bank registers, ROM/SRAM address translation and save handshake.
module cart_ascii_banked
    import cart_pkg::*;
#(
    parameter int          BANK_BITS    = BANK_BITS_ASCII16,
    parameter int          REG_W        = 8,
    parameter int          SRAM_AW      = 13,
    parameter logic [7:0]  SRAM_SEL_MIN = 8'h10,
    parameter int          SRAM_WR_MIN  = (2 ** (15 - BANK_BITS)) / 2,
    parameter logic [23:0] SAVE_DELAY   = 24'd3_579_545
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [24:0]        rom_size,
    input  logic [15:0]        addr,
    input  logic [7:0]         d_from_cpu,
    input  logic               wr,
    input  logic               cs,
    input  logic               sram_en,
    input  logic               save_ack,
    output logic [24:0]        mem_addr,
    output logic               mem_oe,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we,
    output logic               sram_oe,
    output logic               sram_dirty,
    output logic               save_req
);

    localparam int NB_BITS   = 15 - BANK_BITS;
    localparam int NUM_BANKS = 1 << NB_BITS;
    localparam logic [NB_BITS:0] WR_MIN = (NB_BITS + 1)'(SRAM_WR_MIN);

    logic [REG_W-1:0]           bank [NUM_BANKS];
    logic                       reg_sel;
    logic [NB_BITS-1:0]         reg_idx;
    logic                       in_window;
    logic [NB_BITS-1:0]         slot;
    logic [REG_W-1:0]           cur_bank;
    logic [REG_W-1:0]           rom_pages;
    logic [REG_W-1:0]           page_mask;
    logic [REG_W-1:0]           sram_sel;
    logic                       hit;
    logic                       wr_slot_ok;
    logic [REG_W+BANK_BITS-1:0] page_addr;

    // With two banks, addr[11] must be low so only 6000-67FF and 7000-77FF decode.
    assign reg_sel = cs && wr && (addr[15:13] == REG_BASE)
                     && ((NUM_BANKS != 2) || !addr[11]);
    assign reg_idx = addr[12 -: NB_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '0;
        end else if (reg_sel) begin
            bank[reg_idx] <= REG_W'(d_from_cpu);
        end
    end

    assign in_window = (addr >= WIN_LO) && (addr <= WIN_HI);
    assign slot      = NB_BITS'((addr - WIN_LO) >> BANK_BITS);
    assign cur_bank  = bank[slot];

    // An image smaller than one bank yields zero pages, so the mask wraps to all-ones.
    assign rom_pages = REG_W'(rom_size >> BANK_BITS);
    assign page_mask = rom_pages - REG_W'(1);
    assign sram_sel  = (rom_pages > REG_W'(SRAM_SEL_MIN)) ? rom_pages : REG_W'(SRAM_SEL_MIN);

    assign hit        = sram_en && |(cur_bank & sram_sel);
    assign wr_slot_ok = {1'b0, slot} >= WR_MIN;

    assign page_addr = {cur_bank & page_mask, addr[BANK_BITS-1:0]};
    assign mem_addr  = 25'(page_addr);
    assign sram_addr = addr[SRAM_AW-1:0];

    assign mem_oe  = cs && in_window && !hit;
    assign sram_oe = cs && in_window && hit;
    assign sram_we = cs && wr && in_window && hit && wr_slot_ok;

    cart_sram_saver #(
        .SAVE_DELAY(SAVE_DELAY)
    ) u_saver (
        .clk       (clk),
        .reset     (reset),
        .sram_we   (sram_we),
        .save_ack  (save_ack),
        .sram_dirty(sram_dirty),
        .save_req  (save_req)
    );

endmodule

// File: tb/tb_cart_ascii_banked.sv
// Bench: ASCII16 and ASCII8 instances share stimulus and are checked against an arithmetic model.
module tb_cart_ascii_banked;

    localparam int DELAY = 4;

    logic        clk, reset;
    logic [24:0] rom_size;
    logic [15:0] addr;
    logic [7:0]  d_from_cpu;
    logic        wr, cs, sram_en, save_ack;

    logic [24:0] mem_addr   [2];
    logic        mem_oe     [2];
    logic [12:0] sram_addr  [2];
    logic        sram_we    [2];
    logic        sram_oe    [2];
    logic        sram_dirty [2];
    logic        save_req   [2];

    int total = 0;
    int bad   = 0;

    int mbank  [2][4];
    bit mdirty [2];
    bit mreq   [2];
    int msince [2];
    string nm [2] = '{"a16", "a8"};

    cart_ascii_banked #(.BANK_BITS(14), .SAVE_DELAY(24'd4)) u16 (
        .clk(clk), .reset(reset), .rom_size(rom_size), .addr(addr),
        .d_from_cpu(d_from_cpu), .wr(wr), .cs(cs), .sram_en(sram_en),
        .save_ack(save_ack), .mem_addr(mem_addr[0]), .mem_oe(mem_oe[0]),
        .sram_addr(sram_addr[0]), .sram_we(sram_we[0]), .sram_oe(sram_oe[0]),
        .sram_dirty(sram_dirty[0]), .save_req(save_req[0]));

    cart_ascii_banked #(.BANK_BITS(13), .SAVE_DELAY(24'd4)) u8 (
        .clk(clk), .reset(reset), .rom_size(rom_size), .addr(addr),
        .d_from_cpu(d_from_cpu), .wr(wr), .cs(cs), .sram_en(sram_en),
        .save_ack(save_ack), .mem_addr(mem_addr[1]), .mem_oe(mem_oe[1]),
        .sram_addr(sram_addr[1]), .sram_we(sram_we[1]), .sram_oe(sram_oe[1]),
        .sram_dirty(sram_dirty[1]), .save_req(save_req[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bsz(input int i);
        return (i == 0) ? 16384 : 8192;
    endfunction

    function automatic void calc(input int i, output bit inwin, output int s,
                                 output bit hit, output int maddr);
        int bs, pages, mask, sel, bv;
        bs    = bsz(i);
        inwin = (addr >= 16'h4000) && (addr <= 16'hBFFF);
        s     = inwin ? (int'(addr) - 'h4000) / bs : 0;
        pages = (int'(rom_size) / bs) % 256;
        mask  = (pages + 255) % 256;
        sel   = (pages > 16) ? pages : 16;
        bv    = mbank[i][s];
        hit   = sram_en && ((bv & sel) != 0);
        maddr = (bv & mask) * bs + int'(addr) % bs;
    endfunction

    function automatic bit exp_we(input int i);
        bit inwin, hit;
        int s, maddr;
        calc(i, inwin, s, hit, maddr);
        return cs && wr && inwin && hit && (s >= (32768 / bsz(i)) / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) mbank[i][j] = 0;
            mdirty[i] = 0;
            mreq[i]   = 0;
            msince[i] = 0;
        end
    endtask

    task automatic model_update();
        bit we [2];
        int o;
        for (int i = 0; i < 2; i++) we[i] = exp_we(i);
        for (int i = 0; i < 2; i++) begin
            if (we[i]) begin
                mdirty[i] = 1; mreq[i] = 0; msince[i] = 0;
            end else if (mreq[i] && save_ack) begin
                mdirty[i] = 0; mreq[i] = 0;
            end else if (mdirty[i] && !mreq[i]) begin
                msince[i]++;
                if (msince[i] == DELAY + 1) mreq[i] = 1;
            end
        end
        if (cs && wr && addr >= 16'h6000 && addr <= 16'h7FFF) begin
            o = int'(addr) - 'h6000;
            if (o % 4096 < 2048) mbank[0][o / 4096] = d_from_cpu;
            mbank[1][o / 2048] = d_from_cpu;
        end
    endtask

    task automatic check_comb();
        bit inwin, hit;
        int s, maddr;
        for (int i = 0; i < 2; i++) begin
            calc(i, inwin, s, hit, maddr);
            if (inwin) chk({nm[i], "_mem_addr"}, 32'(mem_addr[i]), maddr);
            chk({nm[i], "_mem_oe"},    32'(mem_oe[i]),    32'(cs && inwin && !hit));
            chk({nm[i], "_sram_oe"},   32'(sram_oe[i]),   32'(cs && inwin && hit));
            chk({nm[i], "_sram_we"},   32'(sram_we[i]),   32'(exp_we(i)));
            chk({nm[i], "_sram_addr"}, 32'(sram_addr[i]), int'(addr) % 8192);
        end
    endtask

    task automatic check_seq();
        for (int i = 0; i < 2; i++) begin
            chk({nm[i], "_dirty"},    32'(sram_dirty[i]), 32'(mdirty[i]));
            chk({nm[i], "_save_req"}, 32'(save_req[i]),   32'(mreq[i]));
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; this completes that cycle.
    task automatic cycle();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_update();
        #1;
        check_seq();
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        addr = a; d_from_cpu = d; wr = w; cs = 1'b1; save_ack = 1'b0;
        #2;
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
        drive(a, d, w);
        cycle();
    endtask

    task automatic wait_req(output int n);
        n = 1;
        while (n <= 20) begin
            bus(16'h4000, 8'h00, 1'b0);
            if (save_req[0]) break;
            n++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        reset = 1'b1; rom_size = 25'h40000; addr = 16'h4000; d_from_cpu = 8'h00;
        wr = 1'b0; cs = 1'b1; sram_en = 1'b0; save_ack = 1'b0;
        #12;
        chk("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
        chk("rst_mem_oe",   32'(mem_oe[0]),   32'h1);
        chk("rst_sram_we",  32'(sram_we[0]),  32'h0);
        chk("rst_sram_oe",  32'(sram_oe[0]),  32'h0);
        chk("rst_dirty",    32'(sram_dirty[0]), 32'h0);
        chk("rst_save_req", 32'(save_req[0]),   32'h0);
        #1 reset = 1'b0;
        @(posedge clk); model_update(); #1;

        // ASCII16 mapping
        bus(16'h6000, 8'h05, 1'b1);
        drive(16'h4000, 8'h00, 1'b0);
        chk("t1_map_4000", 32'(mem_addr[0]), 32'h14000);
        chk("t1_oe_4000",  32'(mem_oe[0]),   32'h1);
        cycle();
        bus(16'h7000, 8'h03, 1'b1);
        drive(16'h8123, 8'h00, 1'b0);
        chk("t1_map_8123", 32'(mem_addr[0]), 32'h0C123);
        cycle();

        // ASCII8 mapping
        bus(16'h6000, 8'h01, 1'b1);
        bus(16'h6800, 8'h02, 1'b1);
        bus(16'h7000, 8'h03, 1'b1);
        bus(16'h7800, 8'h04, 1'b1);
        drive(16'h4000, 8'h00, 1'b0); chk("t2_map_4000", 32'(mem_addr[1]), 32'h2000); cycle();
        drive(16'h6000, 8'h00, 1'b0); chk("t2_map_6000", 32'(mem_addr[1]), 32'h4000); cycle();
        drive(16'h8000, 8'h00, 1'b0); chk("t2_map_8000", 32'(mem_addr[1]), 32'h6000); cycle();
        drive(16'hA000, 8'h00, 1'b0); chk("t2_map_A000", 32'(mem_addr[1]), 32'h8000); cycle();
        bus(16'h6400, 8'h07, 1'b1);
        drive(16'h4000, 8'h00, 1'b0); chk("t2_map_6400w", 32'(mem_addr[1]), 32'hE000); cycle();
        drive(16'h0000, 8'h00, 1'b0); chk("t2_oe_0000", 32'(mem_oe[1]), 32'h0); cycle();
        drive(16'hC000, 8'h00, 1'b0); chk("t2_oe_C000", 32'(mem_oe[1]), 32'h0); cycle();

        // SRAM access
        rom_size = 25'h20000; sram_en = 1'b1;
        bus(16'h7000, 8'h10, 1'b1);
        drive(16'h8005, 8'hAA, 1'b1);
        chk("t3_sram_we",   32'(sram_we[0]),   32'h1);
        chk("t3_sram_addr", 32'(sram_addr[0]), 32'h0005);
        chk("t3_mem_oe",    32'(mem_oe[0]),    32'h0);
        cycle();
        bus(16'h6000, 8'h10, 1'b1);
        drive(16'h4005, 8'hAA, 1'b1);
        chk("t3_lo_we", 32'(sram_we[0]), 32'h0);
        chk("t3_lo_oe", 32'(sram_oe[0]), 32'h1);
        cycle();
        sram_en = 1'b0;
        drive(16'h8005, 8'hAA, 1'b1);
        chk("t3_dis_we", 32'(sram_we[0]), 32'h0);
        chk("t3_dis_oe", 32'(sram_oe[0]), 32'h0);
        cycle();
        sram_en = 1'b1;

        // Save handshake
        wait_req(n);
        drive(16'h4000, 8'h00, 1'b0); save_ack = 1'b1; cycle();
        bus(16'h8005, 8'h55, 1'b1);
        chk("t4_dirty", 32'(sram_dirty[0]), 32'h1);
        wait_req(n);
        chk("t4_req_latency", n, 5);
        drive(16'h4000, 8'h00, 1'b0); save_ack = 1'b1; cycle();
        chk("t4_ack_dirty", 32'(sram_dirty[0]), 32'h0);
        chk("t4_ack_req",   32'(save_req[0]),   32'h0);

        // Retrigger and collision
        bus(16'h8005, 8'h11, 1'b1);
        bus(16'h4000, 8'h00, 1'b0);
        bus(16'h4000, 8'h00, 1'b0);
        bus(16'h8006, 8'h22, 1'b1);
        wait_req(n);
        chk("t5_retrig_latency", n, 5);
        drive(16'h8007, 8'h33, 1'b1); save_ack = 1'b1; cycle();
        chk("t5_coll_dirty", 32'(sram_dirty[0]), 32'h1);
        chk("t5_coll_req",   32'(save_req[0]),   32'h0);
        wait_req(n);
        chk("t5_coll_latency", n, 5);

        // Async reset mid-REQ
        drive(16'h4000, 8'h00, 1'b0);
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("t6_req",      32'(save_req[0]),   32'h0);
        chk("t6_dirty",    32'(sram_dirty[0]), 32'h0);
        chk("t6_mem_addr", 32'(mem_addr[0]),   32'h0);
        chk("t6_a8_mem_addr", 32'(mem_addr[1]), 32'h0);
        #2 reset = 1'b0;
        @(posedge clk); model_update(); #1;
        drive(16'h4000, 8'h00, 1'b0); chk("t6_post_map", 32'(mem_addr[0]), 32'h0); cycle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      addr = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
            else if (r < 8) addr = 16'h4000 + 16'($urandom_range(0, 16'h7FFF));
            else            addr = 16'($urandom);
            d_from_cpu = 8'($urandom);
            wr       = ($urandom_range(0, 3) == 0);
            cs       = ($urandom_range(0, 5) != 0);
            save_ack = ($urandom_range(0, 2) == 0);
            if (k % 50 == 0) begin
                sram_en = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 5))
                    0: rom_size = 25'h08000;
                    1: rom_size = 25'h20000;
                    2: rom_size = 25'h40000;
                    3: rom_size = 25'h100000;
                    4: rom_size = 25'h01000;
                    default: rom_size = 25'($urandom);
                endcase
            end
            #2;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_ascii_banked.md
Name: cart_ascii_banked

Overview:
Parametrised ASCII-family MSX cartridge mapper that generalises the fixed two-bank 16 KB ASCII16 mapper to N banks of 8 KB or 16 KB, covering ASCII8 and ASCII16.
It decodes bank-register writes, translates CPU addresses in the 4000h-BFFFh window into the cartridge ROM/SRAM address space, and routes SRAM accesses.
A battery-save handshake tracks SRAM writes and requests a host save after a quiet period.
It sits between the slot decoder (cs) and the SDRAM/BRAM cartridge memory ports.

Parameters:
BANK_BITS, 14, log2 of bank size in bytes. 14 = ASCII16 (2 banks); 13 = ASCII8 (4 banks). NUM_BANKS = 2^(15-BANK_BITS).
REG_W, 8, bank register width. Registers capture d_from_cpu[REG_W-1:0].
SRAM_AW, 13, SRAM address width; must be <= BANK_BITS.
SRAM_SEL_MIN, 8'h10, minimum SRAM-select mask.
SRAM_WR_MIN, NUM_BANKS/2, lowest bank slot index in which SRAM writes are permitted (default: 8000h-BFFFh only).
SAVE_DELAY, 24'd3_579_545, quiet cycles after the last SRAM write before save_req is raised.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rom_size  in  25  ROM image size in bytes
addr  in  16  CPU address
d_from_cpu  in  8  CPU write data
wr  in  1  write strobe
cs  in  1  slot select for this cartridge
sram_en  in  1  cartridge has battery SRAM
save_ack  in  1  host has completed the SRAM save
mem_addr  out  25  ROM byte address
mem_oe  out  1  ROM read enable
sram_addr  out  SRAM_AW  SRAM byte address
sram_we  out  1  SRAM write enable
sram_oe  out  1  SRAM read enable
sram_dirty  out  1  SRAM modified since last save
save_req  out  1  request host to save SRAM

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: all bank registers = 0; sram_dirty = 0; save_req = 0; FSM = IDLE; quiet counter = 0.
- Combinational outputs with all registers at reset: mem_oe = cs && in_window; sram_we = 0; sram_oe = 0.
- Address window: in_window = addr in 4000h-BFFFh.
  - Slot index s = (addr - 4000h) >> BANK_BITS, range 0..NUM_BANKS-1.
  - Outside the window, mem_oe, sram_oe and sram_we are all 0. There is no mirroring.
- Register write: on cs && wr && addr[15:13] == 3'b011, write bank[addr[12 : 13-log2(NUM_BANKS)]].
  - When NUM_BANKS == 2, the write also requires addr[11] == 0 (decodes 6000-67FFh and 7000-77FFh).
  - New value is visible to the address outputs from the next cycle (1-cycle latency).
  - A write held for several cycles is idempotent.
- ROM mapping, combinational:
  - rom_pages = rom_size >> BANK_BITS, truncated to REG_W.
  - mask = rom_pages - 1.
  - mem_addr = zero-extended {bank[s] & mask, addr[BANK_BITS-1:0]}.
  - rom_size below one bank gives mask = all-ones; the image is assumed padded.
- SRAM select:
  - sram_sel = max(rom_pages, SRAM_SEL_MIN).
  - hit = sram_en && ((bank[s] & sram_sel) != 0).
  - sram_oe = cs && in_window && hit.
  - sram_we = cs && wr && in_window && hit && s >= SRAM_WR_MIN.
  - mem_oe = cs && in_window && !hit.
  - sram_addr = addr[SRAM_AW-1:0]. SRAM is mirrored across the bank.
- Save FSM, states IDLE, QUIET, REQ:
  - Any cycle with sram_we: sram_dirty <= 1, counter <= SAVE_DELAY, state <= QUIET. This applies from every state, and in REQ it also drops save_req.
  - QUIET: decrement the counter each cycle. At 0, go to REQ and set save_req = 1.
  - REQ: hold save_req until save_ack. On save_ack without a concurrent sram_we: sram_dirty <= 0, save_req <= 0, go to IDLE.
  - save_ack and sram_we in the same cycle: the write wins. Dirty stays 1; go to QUIET with a reloaded counter.
  - save_ack outside REQ is ignored.
- Reset mid-operation: asynchronous clear of all state. A pending save is lost; the host treats save_req falling without an ack as abort.

Decomposition:
- Shared package cart_pkg:
  - window constants: WIN_LO = 16'h4000, WIN_HI = 16'hBFFF, REG_BASE = 3'b011
  - save FSM state enum {IDLE, QUIET, REQ}
  - ASCII8/ASCII16 BANK_BITS presets
- One sub-module: cart_sram_saver (dirty flag, quiet counter, save FSM). Inputs: sram_we, save_ack. Outputs: sram_dirty, save_req.
- The mapper top contains the decode, bank registers and address muxing.

Test Plan:
1. ASCII16 mapping (BANK_BITS=14): rom_size=25'h40000, write 05h @6000h, read 4000h -> mem_addr=25'h14000, mem_oe=1. Write 03h @7000h, read 8123h -> mem_addr=25'h0C123.
2. ASCII8 mapping (BANK_BITS=13): writes 01h@6000h, 02h@6800h, 03h@7000h, 04h@7800h. Reads 4000h/6000h/8000h/A000h -> mem_addr 2000h/4000h/6000h/8000h. A write @6400h lands in bank0. Reads 0000h and C000h -> mem_oe=0.
3. SRAM access: rom_size=25'h20000, sram_en=1, write 10h @7000h.
   - Write AAh @8005h -> sram_we=1, sram_addr=0005h, mem_oe=0.
   - Bank0=10h: a write @4005h gives sram_we=0 and sram_oe=1.
   - With sram_en=0 the same writes give no SRAM strobes.
4. Save handshake (SAVE_DELAY=4): one SRAM write -> dirty=1. save_req rises 5 cycles later. save_ack -> dirty=0, save_req=0 on the next edge.
5. Collision and retrigger: SRAM write at cycle 2 of QUIET reloads the counter (save_req delayed). sram_we coincident with save_ack -> dirty stays 1, save_req falls, FSM re-enters QUIET.
6. Async reset: assert reset mid-REQ, not aligned to a clk edge -> save_req, dirty and banks clear immediately. After release, read 4000h -> mem_addr=0.
